// File: rtl/sparc_exu_byp_fwd_pkg.sv
// Shared definitions for the EXU operand bypass unit: default widths,
// forwarding source-select codes and the hardwired-zero register address.
package sparc_exu_byp_fwd_pkg;

  localparam int BYP_DW = 64;
  localparam int BYP_AW = 5;

  typedef enum logic [1:0] {
    SRC_E  = 2'd0,
    SRC_M  = 2'd1,
    SRC_W  = 2'd2,
    SRC_RF = 2'd3
  } src_sel_e;

  localparam logic [BYP_AW-1:0] R0 = '0;

endpackage

// File: rtl/sparc_exu_byp_srcsel.sv
// Per-operand forwarding select: picks the youngest in-flight producer of the
// requested register, else register-file data; r0 always reads as zero.
module sparc_exu_byp_srcsel
  import sparc_exu_byp_fwd_pkg::*;
#(
  parameter int DW = BYP_DW,
  parameter int AW = BYP_AW
) (
  input  logic [AW-1:0] addr,
  input  logic          e_vld,
  input  logic [AW-1:0] e_rd,
  input  logic          m_vld,
  input  logic [AW-1:0] m_rd,
  input  logic          w_vld,
  input  logic [AW-1:0] w_rd,
  input  logic          flush_e,
  input  logic [DW-1:0] e_data,
  input  logic [DW-1:0] m_data,
  input  logic [DW-1:0] w_data,
  input  logic [DW-1:0] rf_data,
  output logic [DW-1:0] fwd_data,
  output src_sel_e      sel
);

  logic hit_e;
  logic hit_m;
  logic hit_w;
  logic is_r0;

  assign is_r0 = (addr == R0[AW-1:0]);
  assign hit_e = e_vld & ~flush_e & (addr == e_rd) & ~is_r0;
  assign hit_m = m_vld & (addr == m_rd) & ~is_r0;
  assign hit_w = w_vld & (addr == w_rd) & ~is_r0;

  // Youngest stage wins; r0 falls through to the RF code but forces zero data.
  always_comb begin
    sel      = SRC_RF;
    fwd_data = rf_data;
    if (hit_e) begin
      sel      = SRC_E;
      fwd_data = e_data;
    end else if (hit_m) begin
      sel      = SRC_M;
      fwd_data = m_data;
    end else if (hit_w) begin
      sel      = SRC_W;
      fwd_data = w_data;
    end else if (is_r0) begin
      fwd_data = '0;
    end
  end

endmodule

// File: rtl/sparc_exu_byp_fwd.sv
// EXU bypass/forwarding unit: E/M/W result tag pipeline, register-file
// writeback port and the E-stage operand flops feeding the ALU.
module sparc_exu_byp_fwd
  import sparc_exu_byp_fwd_pkg::*;
#(
  parameter int DW = BYP_DW,
  parameter int AW = BYP_AW
) (
  input  logic          rclk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush_e,
  input  logic [AW-1:0] ifu_byp_rs1_addr_d,
  input  logic [AW-1:0] ifu_byp_rs2_addr_d,
  input  logic [AW-1:0] ifu_byp_rs3_addr_d,
  input  logic [DW-1:0] irf_byp_rs1_data_d,
  input  logic [DW-1:0] irf_byp_rs2_data_d,
  input  logic [DW-1:0] irf_byp_rs3_data_d,
  input  logic [AW-1:0] ifu_byp_rd_addr_d,
  input  logic          ifu_byp_wen_d,
  input  logic [DW-1:0] alu_byp_rd_data_e,
  output logic [DW-1:0] byp_alu_rs1_data_e,
  output logic [DW-1:0] byp_alu_rs2_data_e_l,
  output logic [DW-1:0] byp_alu_rs3_data_e,
  output logic [DW-1:0] byp_alu_rcc_data_e,
  output logic [DW-1:0] byp_irf_rd_data_w,
  output logic [AW-1:0] byp_irf_rd_addr_w,
  output logic          byp_irf_wen_w
);

  logic          e_vld, m_vld, w_vld;
  logic [AW-1:0] e_rd, m_rd, w_rd;
  logic [DW-1:0] m_data, w_data;
  logic [DW-1:0] rs1_fwd, rs2_fwd, rs3_fwd;
  src_sel_e      rs1_sel, rs2_sel, rs3_sel;
  logic [5:0]    unused_sel;

  // Select codes are exposed for debug visibility only.
  assign unused_sel = {rs1_sel, rs2_sel, rs3_sel};

  sparc_exu_byp_srcsel #(.DW(DW), .AW(AW)) u_rs1_sel (
    .addr(ifu_byp_rs1_addr_d), .e_vld(e_vld), .e_rd(e_rd), .m_vld(m_vld),
    .m_rd(m_rd), .w_vld(w_vld), .w_rd(w_rd), .flush_e(flush_e),
    .e_data(alu_byp_rd_data_e), .m_data(m_data), .w_data(w_data),
    .rf_data(irf_byp_rs1_data_d), .fwd_data(rs1_fwd), .sel(rs1_sel)
  );

  sparc_exu_byp_srcsel #(.DW(DW), .AW(AW)) u_rs2_sel (
    .addr(ifu_byp_rs2_addr_d), .e_vld(e_vld), .e_rd(e_rd), .m_vld(m_vld),
    .m_rd(m_rd), .w_vld(w_vld), .w_rd(w_rd), .flush_e(flush_e),
    .e_data(alu_byp_rd_data_e), .m_data(m_data), .w_data(w_data),
    .rf_data(irf_byp_rs2_data_d), .fwd_data(rs2_fwd), .sel(rs2_sel)
  );

  sparc_exu_byp_srcsel #(.DW(DW), .AW(AW)) u_rs3_sel (
    .addr(ifu_byp_rs3_addr_d), .e_vld(e_vld), .e_rd(e_rd), .m_vld(m_vld),
    .m_rd(m_rd), .w_vld(w_vld), .w_rd(w_rd), .flush_e(flush_e),
    .e_data(alu_byp_rd_data_e), .m_data(m_data), .w_data(w_data),
    .rf_data(irf_byp_rs3_data_d), .fwd_data(rs3_fwd), .sel(rs3_sel)
  );

  // Result tag pipeline; a flushed E instruction enters M as invalid.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      e_vld  <= 1'b0;
      e_rd   <= '0;
      m_vld  <= 1'b0;
      m_rd   <= '0;
      m_data <= '0;
      w_vld  <= 1'b0;
      w_rd   <= '0;
      w_data <= '0;
    end else if (!stall) begin
      e_vld  <= ifu_byp_wen_d & (ifu_byp_rd_addr_d != R0[AW-1:0]);
      e_rd   <= ifu_byp_rd_addr_d;
      m_vld  <= e_vld & ~flush_e;
      m_rd   <= e_rd;
      m_data <= alu_byp_rd_data_e;
      w_vld  <= m_vld;
      w_rd   <= m_rd;
      w_data <= m_data;
    end
  end

  // Operand flops; rs2 is kept inverted so its reset value is all ones.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      byp_alu_rs1_data_e   <= '0;
      byp_alu_rs2_data_e_l <= '1;
      byp_alu_rs3_data_e   <= '0;
      byp_alu_rcc_data_e   <= '0;
    end else if (!stall) begin
      byp_alu_rs1_data_e   <= rs1_fwd;
      byp_alu_rs2_data_e_l <= ~rs2_fwd;
      byp_alu_rs3_data_e   <= rs3_fwd;
      byp_alu_rcc_data_e   <= rs1_fwd;
    end
  end

  assign byp_irf_wen_w     = w_vld;
  assign byp_irf_rd_addr_w = w_rd;
  assign byp_irf_rd_data_w = w_data;

endmodule

// File: doc/sparc_exu_byp_fwd.md
Name: sparc_exu_byp_fwd

Overview:
Operand bypass/forwarding unit on the producer side of the ALU operand interface.
- Captures the ALU result at E and pipes it through M and W with destination tags.
- Drives the W-stage register-file write port.
- At D, selects each source operand from E/M/W forwarding or register-file read data, then registers it into the E-stage operand flops that feed the ALU.
- rs2 is delivered inverted, as the ALU expects.

Parameters:
DW, 64, datapath width
AW, 5, register address width (r0 hardwired zero)

Ports:
rclk  in  1  clock
reset  in  1  asynchronous active-high reset
stall  in  1  holds all pipeline and operand registers
flush_e  in  1  kills the instruction currently in E (its result is not forwarded or written)
ifu_byp_rs1_addr_d  in  AW  rs1 address at D
ifu_byp_rs2_addr_d  in  AW  rs2 address at D
ifu_byp_rs3_addr_d  in  AW  rs3 address at D
irf_byp_rs1_data_d  in  DW  register-file read data for rs1
irf_byp_rs2_data_d  in  DW  register-file read data for rs2
irf_byp_rs3_data_d  in  DW  register-file read data for rs3
ifu_byp_rd_addr_d  in  AW  destination of the D instruction
ifu_byp_wen_d  in  1  D instruction writes rd
alu_byp_rd_data_e  in  DW  ALU result at E (combinational)
byp_alu_rs1_data_e  out  DW  E-stage operand 1
byp_alu_rs2_data_e_l  out  DW  E-stage operand 2, inverted
byp_alu_rs3_data_e  out  DW  E-stage operand 3
byp_alu_rcc_data_e  out  DW  register-condition operand (the rs1 value)
byp_irf_rd_data_w  out  DW  writeback data
byp_irf_rd_addr_w  out  AW  writeback address
byp_irf_wen_w  out  1  writeback enable

Behaviour:
Reset (asynchronous, active-high):
- All valids 0; all tags 0; all data registers 0.
- byp_alu_rs1/rs3/rcc_data_e = 0.
- byp_alu_rs2_data_e_l = all ones.
- byp_irf_wen_w = 0; byp_irf_rd_addr_w = 0; byp_irf_rd_data_w = 0.
- Reset mid-operation discards all in-flight results.

Tag pipeline:
- D->E: e_vld <= ifu_byp_wen_d & (rd != 0); e_rd <= ifu_byp_rd_addr_d.
- E->M:
  - m_vld <= e_vld & ~flush_e.
  - m_rd <= e_rd.
  - m_data <= alu_byp_rd_data_e.
- M->W: w_vld/w_rd/w_data <= m_vld/m_rd/m_data.
- Writeback outputs = W registers.

Forwarding mux, per operand, evaluated at D, priority highest first:
- E: e_vld & ~flush_e & addr==e_rd -> alu_byp_rd_data_e
- M: m_vld & addr==m_rd -> m_data
- W: w_vld & addr==w_rd -> w_data (covers same-cycle write/read)
- otherwise: register-file data
- Address 0 never matches and always yields 0, regardless of register-file data.

Operand registers:
- Load the mux results each non-stalled cycle.
- rs2 is stored inverted (~value).
- rcc equals the forwarded rs1 value, registered separately.
- Latency: D operand to E output is 1 cycle.
- A result is forwardable in the cycle it appears at E.
- A result reaches the register file 2 cycles after E.

Stall:
- All registers hold, including the W stage.
- byp_irf_wen_w stays asserted while stalled; the register-file write is idempotent.

flush_e together with stall: stall wins. The flush is re-sampled on the next unstalled cycle.

Multiple matches: the youngest stage wins. Example: E and W both hold r5 -> use E.

Decomposition:
Shared package:
- DW/AW defaults.
- Source-select encoding: SRC_E=2'd0, SRC_M=2'd1, SRC_W=2'd2, SRC_RF=2'd3.
- R0 constant.

Sub-module:
- sparc_exu_byp_srcsel (combinational, instantiated 3x).
- Inputs: address, e/m/w tags and valids, flush_e, four data inputs.
- Outputs: forwarded data and the select code.
- Pipeline and operand registers stay in the top module.

Test Plan:
1. Reset asserted mid-stream with valid M/W entries -> next cycle rs2_l = 64'hFFFF_FFFF_FFFF_FFFF, rs1 = 0, wen_w = 0; no stale forwards after release.
2. Back-to-back dependency:
   - I1 writes r3; ALU result at E = 64'h1234.
   - I2 at D reads rs1=r3; RF returns 64'hDEAD.
   - -> next cycle byp_alu_rs1_data_e = 64'h1234, rcc = 64'h1234.
3. Priority and stage forwarding:
   - E result for r7 = 64'hA, W result for r7 = 64'hB -> forwarded value is 64'hA.
   - With E not writing r7, M holds r7 = 64'hC -> 64'hC.
4. r0 handling:
   - rd=0 with wen=1, result 64'h55 -> never forwarded.
   - rs2=r0 -> byp_alu_rs2_data_e_l = all ones.
   - byp_irf_wen_w = 0 two cycles later.
5. flush_e on a r4 producer:
   - -> same-cycle D read of r4 takes the RF value.
   - -> M/W never assert a write for r4.
6. stall held 3 cycles with an r9 result in W:
   - -> byp_irf_wen_w stays asserted, operands unchanged.
   - -> on release, the pipeline advances exactly one stage.
